wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
// - Shares the single register-file write port among three writeback sources:
//   the in-order pipeline, the multi-cycle mul/div unit (MDU), and the load/store unit (LSU).
// - Sits between these producers and the regfile write port, alongside the writeback-select logic.
// - The pipeline has default priority. MDU and LSU alternate round-robin.
// - A starvation counter temporarily lifts a waiting side source above the pipeline.
// PARAMETERS
// - XLEN          64   data width of each write value
// - REG_ADDR_W    5    register index width
// - STARVE_LIMIT  8    wait cycles after which a side source overrides the pipeline (>=1)
// PORTS
// - clk         input   1           clock; all state updates on the rising edge
// - rst         input   1           asynchronous reset, active-low (0 = reset)
// - pipe_valid  input   1           pipeline write request
// - pipe_rd     input   REG_ADDR_W  pipeline destination register
// - pipe_data   input   XLEN        pipeline write value
// - pipe_ready  output  1           pipeline request accepted this cycle
// - mdu_valid   input   1           MDU write request
// - mdu_rd      input   REG_ADDR_W  MDU destination register
// - mdu_data    input   XLEN        MDU write value
// - mdu_ready   output  1           MDU request accepted this cycle
// - lsu_valid   input   1           LSU load-data write request
// - lsu_rd      input   REG_ADDR_W  LSU destination register
// - lsu_data    input   XLEN        LSU write value
// - lsu_ready   output  1           LSU request accepted this cycle
// - w_ena       output  1           regfile write enable (registered)
// - w_addr      output  REG_ADDR_W  regfile write index (registered)
// - w_data      output  XLEN        regfile write data (registered)
// - wb_src      output  2           source of current write: 0 none, 1 pipe, 2 mdu, 3 lsu
// BEHAVIOUR
// - Handshake rules
//   - A transfer happens when X_valid & X_ready in the same cycle.
//   - A requester holds valid, rd and data stable until accepted; valid must not depend on ready.
//   - *_ready is combinational from the valids and arbiter state.
//   - At most one *_ready is high in any cycle.
//   - A ready is never high while its valid is low.
// - Grant order, evaluated every cycle
//   1. A starved side source wins. If MDU and LSU are both starved, the RR pointer picks between them.
//   2. Otherwise pipe_valid wins.
//   3. Otherwise MDU/LSU are served by the RR pointer. A lone valid side source wins regardless of the pointer.
// - RR pointer
//   - 1 bit; reset value selects MDU.
//   - After any MDU grant it points to LSU; after any LSU grant it points to MDU.
//   - Pipe grants leave it unchanged.
// - Starvation counters (MDU and LSU each have one)
//   - Width $clog2(STARVE_LIMIT+1).
//   - Increments each cycle its valid=1 and ready=0; saturates at STARVE_LIMIT.
//   - Cleared on that source's grant, and in any cycle its valid=0.
//   - starved = (count == STARVE_LIMIT).
//   - Once starved, the source is granted in the same cycle the counter reads STARVE_LIMIT, subject to rule 1.
// - Output latency
//   - A grant in cycle N produces w_ena/w_addr/w_data/wb_src in cycle N+1, held for exactly one cycle.
//   - With no grant in cycle N: w_ena=0, w_addr=0, w_data=0, wb_src=0 in N+1.
// - x0 destination
//   - A request with rd==0 is accepted normally and updates the pointer and counter.
//   - In N+1 it drives w_ena=0, w_addr=0, w_data=0, with wb_src still naming the source.
// - Throughput
//   - One write per cycle, back-to-back.
//   - No internal buffering: an ungranted request simply waits.
// - Reset
//   - While rst=0: w_ena=0, w_addr=0, w_data=0, wb_src=0, both counters 0, pointer=MDU.
//   - All *_ready are forced 0 combinationally.
//   - Assertion mid-operation discards any grant registered but not yet output.
//   - Requesters re-present after reset; the arbiter does not replay them.
//   - First possible grant is the first clock edge with rst=1.
// TESTING
// - Reset check: rst=0 with all valids=1 -> all readys 0, w_ena=0, wb_src=0; release rst -> pipe granted first cycle, wb_src=1 next.
// - Single write: pipe_valid=1, rd=5, data=64'hDEAD_BEEF -> pipe_ready=1 in N; N+1 gives w_ena=1, w_addr=5, w_data=64'hDEAD_BEEF, wb_src=1; N+2 gives w_ena=0.
// - Round-robin: MDU and LSU valid continuously, pipe idle -> grants MDU, LSU, MDU, LSU (wb_src 2,3,2,3); rd=3/7 with distinct data appear in order.
// - Starvation: pipe valid every cycle, MDU valid from cycle 0 (rd=9) -> pipe granted cycles 0..7; cycle 8 mdu_ready=1, pipe_ready=0; cycle 9 w_addr=9, wb_src=2; pipe resumes cycle 9.
// - x0 write: lsu_valid=1, rd=0, data=64'h1234 -> lsu_ready=1; next cycle w_ena=0, w_data=0, wb_src=3; pointer moves to MDU.
// - Reset mid-flight: grant MDU in cycle N, assert rst in N before the edge -> w_ena stays 0; counters 0 and pointer=MDU after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the single regfile write port.
// Pipe has default priority, MDU/LSU round-robin, starvation override.
module wb_arbiter #(
    parameter int XLEN         = 64,
    parameter int REG_ADDR_W   = 5,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_valid,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_ready,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  mdu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  lsu_ready,
    output logic                  w_ena,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [XLEN-1:0]       w_data,
    output logic [1:0]            wb_src
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MDU  = 2'd2,
        SRC_LSU  = 2'd3
    } src_e;

    // rr_q: 0 selects MDU next, 1 selects LSU next
    logic                  rr_q, rr_d;
    logic [CW-1:0]         mdu_cnt_q, mdu_cnt_d;
    logic [CW-1:0]         lsu_cnt_q, lsu_cnt_d;
    logic                  w_ena_q, w_ena_d;
    logic [REG_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [XLEN-1:0]       w_data_q, w_data_d;
    src_e                  src_q, src_d;

    src_e                  gnt;
    logic                  mdu_starved;
    logic                  lsu_starved;
    logic                  rr_pick;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    assign mdu_starved = mdu_valid && (mdu_cnt_q == LIM);
    assign lsu_starved = lsu_valid && (lsu_cnt_q == LIM);
    assign rr_pick     = rr_q;

    // Grant selection: starved side source, then pipe, then round-robin
    always_comb begin
        gnt = SRC_NONE;
        if (!rst) begin
            gnt = SRC_NONE;
        end else if (mdu_starved && lsu_starved) begin
            gnt = rr_pick ? SRC_LSU : SRC_MDU;
        end else if (mdu_starved) begin
            gnt = SRC_MDU;
        end else if (lsu_starved) begin
            gnt = SRC_LSU;
        end else if (pipe_valid) begin
            gnt = SRC_PIPE;
        end else if (mdu_valid && lsu_valid) begin
            gnt = rr_pick ? SRC_LSU : SRC_MDU;
        end else if (mdu_valid) begin
            gnt = SRC_MDU;
        end else if (lsu_valid) begin
            gnt = SRC_LSU;
        end
    end

    assign pipe_ready = (gnt == SRC_PIPE);
    assign mdu_ready  = (gnt == SRC_MDU);
    assign lsu_ready  = (gnt == SRC_LSU);

    // Route the winning request toward the write-port registers
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        case (gnt)
            SRC_PIPE: begin
                sel_rd   = pipe_rd;
                sel_data = pipe_data;
            end
            SRC_MDU: begin
                sel_rd   = mdu_rd;
                sel_data = mdu_data;
            end
            SRC_LSU: begin
                sel_rd   = lsu_rd;
                sel_data = lsu_data;
            end
            default: begin
                sel_rd   = '0;
                sel_data = '0;
            end
        endcase
    end

    // Next write-port values; x0 writes are suppressed but keep their source tag
    always_comb begin
        w_ena_d  = (gnt != SRC_NONE) && (sel_rd != '0);
        w_addr_d = w_ena_d ? sel_rd : '0;
        w_data_d = w_ena_d ? sel_data : '0;
        src_d    = gnt;
    end

    // Pointer and starvation counter next state
    always_comb begin
        rr_d = rr_q;
        if (gnt == SRC_MDU) begin
            rr_d = 1'b1;
        end else if (gnt == SRC_LSU) begin
            rr_d = 1'b0;
        end

        mdu_cnt_d = mdu_cnt_q;
        if (!mdu_valid || gnt == SRC_MDU) begin
            mdu_cnt_d = '0;
        end else if (mdu_cnt_q != LIM) begin
            mdu_cnt_d = mdu_cnt_q + CW'(1);
        end

        lsu_cnt_d = lsu_cnt_q;
        if (!lsu_valid || gnt == SRC_LSU) begin
            lsu_cnt_d = '0;
        end else if (lsu_cnt_q != LIM) begin
            lsu_cnt_d = lsu_cnt_q + CW'(1);
        end
    end

    // State and registered write-port outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q      <= 1'b0;
            mdu_cnt_q <= '0;
            lsu_cnt_q <= '0;
            w_ena_q   <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
            src_q     <= SRC_NONE;
        end else begin
            rr_q      <= rr_d;
            mdu_cnt_q <= mdu_cnt_d;
            lsu_cnt_q <= lsu_cnt_d;
            w_ena_q   <= w_ena_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
            src_q     <= src_d;
        end
    end

    assign w_ena  = w_ena_q;
    assign w_addr = w_addr_q;
    assign w_data = w_data_q;
    assign wb_src = src_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_arbiter;

    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int LIM  = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pipe_valid = 1'b0;
    logic [RW-1:0]   pipe_rd = '0;
    logic [XLEN-1:0] pipe_data = '0;
    logic            pipe_ready;
    logic            mdu_valid = 1'b0;
    logic [RW-1:0]   mdu_rd = '0;
    logic [XLEN-1:0] mdu_data = '0;
    logic            mdu_ready;
    logic            lsu_valid = 1'b0;
    logic [RW-1:0]   lsu_rd = '0;
    logic [XLEN-1:0] lsu_data = '0;
    logic            lsu_ready;
    logic            w_ena;
    logic [RW-1:0]   w_addr;
    logic [XLEN-1:0] w_data;
    logic [1:0]      wb_src;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arbiter #(
        .XLEN(XLEN),
        .REG_ADDR_W(RW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pipe_valid(pipe_valid),
        .pipe_rd(pipe_rd),
        .pipe_data(pipe_data),
        .pipe_ready(pipe_ready),
        .mdu_valid(mdu_valid),
        .mdu_rd(mdu_rd),
        .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .lsu_valid(lsu_valid),
        .lsu_rd(lsu_rd),
        .lsu_data(lsu_data),
        .lsu_ready(lsu_ready),
        .w_ena(w_ena),
        .w_addr(w_addr),
        .w_data(w_data),
        .wb_src(wb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // wait counts in cycles; rr_lsu=1 means LSU is next in turn
    int       m_wait = 0;
    int       l_wait = 0;
    bit       rr_lsu = 1'b0;
    int       g_now;
    bit       e_ena = 1'b0;
    int       e_addr = 0;
    logic [63:0] e_data = '0;
    int       e_src = 0;

    // returns 0 none, 1 pipe, 2 mdu, 3 lsu
    function automatic int pick(input logic r, input logic pv,
                                input logic mv, input logic lv,
                                input int mw, input int lw,
                                input bit rl);
        bit ms;
        bit ls;
        ms = mv && (mw >= LIM);
        ls = lv && (lw >= LIM);
        if (!r) return 0;
        if (ms && ls) return rl ? 3 : 2;
        if (ms) return 2;
        if (ls) return 3;
        if (pv) return 1;
        if (mv && lv) return rl ? 3 : 2;
        if (mv) return 2;
        if (lv) return 3;
        return 0;
    endfunction

    function automatic int rd_of(input int g);
        if (g == 1) return int'(pipe_rd);
        if (g == 2) return int'(mdu_rd);
        if (g == 3) return int'(lsu_rd);
        return 0;
    endfunction

    function automatic logic [63:0] data_of(input int g);
        if (g == 1) return pipe_data;
        if (g == 2) return mdu_data;
        if (g == 3) return lsu_data;
        return 64'd0;
    endfunction

    always_comb g_now = pick(rst, pipe_valid, mdu_valid, lsu_valid,
                             m_wait, l_wait, rr_lsu);

    always @(posedge clk) begin
        if (!rst) begin
            m_wait <= 0;
            l_wait <= 0;
            rr_lsu <= 1'b0;
            e_ena  <= 1'b0;
            e_addr <= 0;
            e_data <= '0;
            e_src  <= 0;
        end else begin
            e_src  <= g_now;
            e_ena  <= (g_now != 0) && (rd_of(g_now) != 0);
            e_addr <= (g_now != 0 && rd_of(g_now) != 0) ? rd_of(g_now) : 0;
            e_data <= (g_now != 0 && rd_of(g_now) != 0) ? data_of(g_now) : '0;
            m_wait <= (!mdu_valid || g_now == 2) ? 0 :
                      (m_wait < LIM ? m_wait + 1 : m_wait);
            l_wait <= (!lsu_valid || g_now == 3) ? 0 :
                      (l_wait < LIM ? l_wait + 1 : l_wait);
            if (g_now == 2) rr_lsu <= 1'b1;
            else if (g_now == 3) rr_lsu <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the edge
    always @(negedge clk) begin
        logic [2:0] er;
        er = {g_now == 1, g_now == 2, g_now == 3};
        chk("model_ready", {61'd0, pipe_ready, mdu_ready, lsu_ready},
            {61'd0, er});
        chk("model_ena", {63'd0, w_ena}, {63'd0, rst ? e_ena : 1'b0});
        chk("model_addr", {59'd0, w_addr},
            rst ? 64'(e_addr) : 64'd0);
        chk("model_data", w_data, rst ? e_data : 64'd0);
        chk("model_src", {62'd0, wb_src}, rst ? 64'(e_src) : 64'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    initial begin
        // reset with every requester asking
        rst = 1'b0;
        pipe_valid = 1'b1; pipe_rd = 5'd1; pipe_data = 64'h11;
        mdu_valid  = 1'b1; mdu_rd  = 5'd3; mdu_data  = 64'hAAAA_0001;
        lsu_valid  = 1'b1; lsu_rd  = 5'd7; lsu_data  = 64'hBBBB_0002;
        step();
        step();
        neg();
        chk("rst_readys", {61'd0, pipe_ready, mdu_ready, lsu_ready}, 64'd0);
        chk("rst_wena", {63'd0, w_ena}, 64'd0);
        chk("rst_src", {62'd0, wb_src}, 64'd0);
        step();
        rst = 1'b1;
        neg();
        chk("rel_pipe_ready", {63'd0, pipe_ready}, 64'd1);
        chk("rel_mdu_ready", {63'd0, mdu_ready}, 64'd0);
        step();
        pipe_valid = 1'b0; mdu_valid = 1'b0; lsu_valid = 1'b0;
        neg();
        chk("rel_src", {62'd0, wb_src}, 64'd1);
        chk("rel_wena", {63'd0, w_ena}, 64'd1);
        step();

        // single pipe write
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 64'hDEAD_BEEF;
        neg();
        chk("single_ready", {63'd0, pipe_ready}, 64'd1);
        step();
        pipe_valid = 1'b0;
        neg();
        chk("single_ena", {63'd0, w_ena}, 64'd1);
        chk("single_addr", {59'd0, w_addr}, 64'd5);
        chk("single_data", w_data, 64'hDEAD_BEEF);
        chk("single_src", {62'd0, wb_src}, 64'd1);
        step();
        neg();
        chk("single_ena_off", {63'd0, w_ena}, 64'd0);
        step();

        // round-robin MDU/LSU
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'hAAAA_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'hBBBB_0002;
        for (int i = 0; i < 5; i++) begin
            neg();
            if (i < 4) begin
                chk("rr_mdu_ready", {63'd0, mdu_ready},
                    (i % 2 == 0) ? 64'd1 : 64'd0);
                chk("rr_lsu_ready", {63'd0, lsu_ready},
                    (i % 2 == 1) ? 64'd1 : 64'd0);
            end
            if (i > 0) begin
                chk("rr_src", {62'd0, wb_src},
                    (i % 2 == 1) ? 64'd2 : 64'd3);
                chk("rr_addr", {59'd0, w_addr},
                    (i % 2 == 1) ? 64'd3 : 64'd7);
                chk("rr_data", w_data,
                    (i % 2 == 1) ? 64'hAAAA_0001 : 64'hBBBB_0002);
            end
            step();
            if (i == 3) begin
                mdu_valid = 1'b0;
                lsu_valid = 1'b0;
            end
        end

        // starvation of MDU behind a busy pipe
        pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 64'h22;
        mdu_valid  = 1'b1; mdu_rd  = 5'd9; mdu_data  = 64'h99;
        for (int i = 0; i < 10; i++) begin
            neg();
            if (i < 8) begin
                chk("stv_pipe_ready", {63'd0, pipe_ready}, 64'd1);
                chk("stv_mdu_wait", {63'd0, mdu_ready}, 64'd0);
            end else if (i == 8) begin
                chk("stv_mdu_ready", {63'd0, mdu_ready}, 64'd1);
                chk("stv_pipe_block", {63'd0, pipe_ready}, 64'd0);
            end else begin
                chk("stv_addr", {59'd0, w_addr}, 64'd9);
                chk("stv_src", {62'd0, wb_src}, 64'd2);
                chk("stv_pipe_resume", {63'd0, pipe_ready}, 64'd1);
            end
            step();
            if (i == 8) mdu_valid = 1'b0;
            if (i == 9) pipe_valid = 1'b0;
        end

        // x0 destination from LSU
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h1234;
        neg();
        chk("x0_ready", {63'd0, lsu_ready}, 64'd1);
        step();
        lsu_valid = 1'b0;
        neg();
        chk("x0_ena", {63'd0, w_ena}, 64'd0);
        chk("x0_data", w_data, 64'd0);
        chk("x0_addr", {59'd0, w_addr}, 64'd0);
        chk("x0_src", {62'd0, wb_src}, 64'd3);
        step();
        mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 64'hAAAA_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'hBBBB_0002;
        neg();
        chk("x0_ptr_mdu", {63'd0, mdu_ready}, 64'd1);
        step();
        lsu_valid = 1'b0;

        // reset mid-flight with pointer at LSU
        neg();
        chk("mid_mdu_ready", {63'd0, mdu_ready}, 64'd1);
        #2;
        rst = 1'b0;
        step();
        neg();
        chk("mid_wena", {63'd0, w_ena}, 64'd0);
        chk("mid_ready_off", {63'd0, mdu_ready}, 64'd0);
        step();
        rst = 1'b1;
        lsu_valid = 1'b1;
        neg();
        chk("mid_ptr_mdu", {63'd0, mdu_ready}, 64'd1);
        chk("mid_ptr_lsu", {63'd0, lsu_ready}, 64'd0);
        step();
        mdu_valid = 1'b0;
        neg();
        chk("mid_lsu_next", {63'd0, lsu_ready}, 64'd1);
        step();
        lsu_valid = 1'b0;

        // counters cleared by reset: build LSU wait, reset, re-count
        pipe_valid = 1'b1;
        lsu_valid  = 1'b1;
        for (int i = 0; i < 4; i++) step();
        neg();
        #2;
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            neg();
            if (i < 8) begin
                chk("cnt_pipe_ready", {63'd0, pipe_ready}, 64'd1);
            end else begin
                chk("cnt_lsu_ready", {63'd0, lsu_ready}, 64'd1);
            end
            step();
            if (i == 8) lsu_valid = 1'b0;
        end
        pipe_valid = 1'b0;
        step();
        step();
        neg();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
